// File: rtl/rssb_pkg.sv
// RSSB sequencer shared types and program-counter helpers.
package rssb_pkg;

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_HALT
   } state_t;

   function automatic logic [31:0] rom_base(input int unsigned width);
      return 32'd1 << (width - 1);
   endfunction

   // The ROM-select MSB stays pinned; only the low bits wrap.
   function automatic logic [31:0] pc_next(
      input logic [31:0] pc,
      input logic        skip,
      input int unsigned width
   );
      logic [31:0] low_mask;
      low_mask = rom_base(width) - 32'd1;
      return rom_base(width) | ((pc + (skip ? 32'd2 : 32'd1)) & low_mask);
   endfunction

endpackage

// File: rtl/rssb_alu.sv
// RSSB subtract unit: diff = mem[A] - acc, skip on a negative result.
module rssb_alu
   import rssb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic signed [WIDTH-1:0] mem_rdata,
   input  logic signed [WIDTH-1:0] acc,
   output logic        [WIDTH-1:0] diff,
   output logic                    skip
);

   assign diff = mem_rdata - acc;
   assign skip = diff[WIDTH-1];

endmodule

// File: rtl/rssb_sequencer.sv
// RSSB one-instruction core sequencer, two cycles per instruction.
// Optional output port remap enabled by RSSB_OUTPORT_EN.
module rssb_sequencer
   import rssb_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] HALT_ADDR = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] OUT_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] mem_rdata,
   output logic        [WIDTH-1:0] mem_addr,
   output logic        [WIDTH-1:0] mem_wdata,
   output logic                    mem_write,
   output logic        [WIDTH-1:0] pc,
   output logic signed [WIDTH-1:0] acc,
   output logic                    instr_done,
   output logic                    halted,
   output logic        [WIDTH-1:0] out_data,
   output logic                    out_valid
);

   localparam logic [WIDTH-1:0] ROM_BASE = WIDTH'(rom_base(WIDTH));

   state_t                  state, state_n;
   logic        [WIDTH-1:0] opnd, opnd_n;
   logic        [WIDTH-1:0] pc_n;
   logic signed [WIDTH-1:0] acc_n;
   logic        [WIDTH-1:0] diff;
   logic                    skip;
   logic                    done_n;
   logic                    out_hit;

   rssb_alu #(.WIDTH(WIDTH)) u_alu (
      .mem_rdata (mem_rdata),
      .acc       (acc),
      .diff      (diff),
      .skip      (skip)
   );

   assign mem_wdata = diff;
   assign halted    = (state == S_HALT);

   always_comb begin
      state_n   = state;
      opnd_n    = opnd;
      pc_n      = pc;
      acc_n     = acc;
      done_n    = 1'b0;
      mem_addr  = pc;
      mem_write = 1'b0;
      unique case (state)
         S_FETCH: begin
            if (en) begin
               opnd_n  = mem_rdata;
               state_n = ($unsigned(mem_rdata) == HALT_ADDR) ? S_HALT : S_EXEC;
            end
         end
         S_EXEC: begin
            mem_addr  = opnd;
            // ROM targets and the output port never reach memory.
            mem_write = en & ~opnd[WIDTH-1] & ~out_hit & ~rst;
            if (en) begin
               acc_n   = diff;
               pc_n    = WIDTH'(pc_next(32'(pc), skip, WIDTH));
               done_n  = 1'b1;
               state_n = S_FETCH;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FETCH;
         pc         <= ROM_BASE;
         acc        <= '0;
         opnd       <= '0;
         instr_done <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         acc        <= acc_n;
         opnd       <= opnd_n;
         instr_done <= done_n;
      end
   end

`ifdef RSSB_OUTPORT_EN
   assign out_hit = (opnd == OUT_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= en & out_hit & (state == S_EXEC);
         if (en & out_hit & (state == S_EXEC)) out_data <= diff;
      end
   end
`else
   logic unused_out_addr;
   assign unused_out_addr = ^OUT_ADDR;
   assign out_hit         = 1'b0;
   assign out_data        = '0;
   assign out_valid       = 1'b0;
`endif

endmodule

// File: doc/rssb_sequencer.md
Name: rssb_sequencer

Overview:
- Memory-side initiator and instruction sequencer for the RSSB one-instruction core.
- Drives address, write-data and write-strobe into the data-memory block, which reads combinationally and writes synchronously; lower half is RAM, upper half (address MSB = 1) is ROM.
- Executes RSSB: acc <= mem[A] - acc; mem[A] <= result; skip next instruction if the result is negative.
- Two cycles per instruction; program lives in ROM.

Parameters:
- WIDTH, 8: data/address width in bits.
- HALT_ADDR, {WIDTH{1'b1}}: operand value that halts the core.
- OUT_ADDR, 0: RAM address remapped to the output port (used only when RSSB_OUTPORT_EN is defined).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 freezes all state and suppresses writes.
- mem_rdata  input  WIDTH (signed)  combinational read data from data memory.
- mem_addr  output  WIDTH  memory address; combinational from state.
- mem_wdata  output  WIDTH  write data; equals the current subtraction result.
- mem_write  output  1  write strobe; memory samples it on the next clk edge.
- pc  output  WIDTH  current program counter (registered).
- acc  output  WIDTH (signed)  accumulator (registered).
- instr_done  output  1  one-cycle pulse on each completed EXEC.
- halted  output  1  high in HALT.
- out_data  output  WIDTH  output-port value.
- out_valid  output  1  one-cycle pulse when out_data is updated.

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - state=FETCH, pc=ROM_BASE (2^(WIDTH-1), 0x80 for WIDTH=8), acc=0, opnd=0.
  - instr_done=0, halted=0, out_data=0, out_valid=0.
  - mem_write is forced to 0 combinationally while rst is high.
- FETCH:
  - mem_addr=pc, mem_write=0.
  - If en: opnd <= mem_rdata. Next state is HALT if mem_rdata==HALT_ADDR, else EXEC.
- EXEC:
  - mem_addr=opnd.
  - diff = mem_rdata - acc, computed modulo 2^WIDTH.
  - mem_wdata=diff.
  - mem_write = en & ~opnd[WIDTH-1]. A ROM target is never written, but acc still updates.
  - If en:
    - acc <= diff.
    - pc <= pc+2 if diff[WIDTH-1]==1 (borrow/skip), else pc+1.
    - instr_done <= 1.
    - Next state FETCH.
- HALT: terminal; mem_write=0, halted=1, pc/acc frozen. Only rst exits.
- en=0 in any state: no register changes, mem_write=0, instr_done=0; mem_addr keeps tracking the state.
- PC wrap: pc MSB is always 1. Increment is done on the low WIDTH-1 bits modulo 2^(WIDTH-1):
  - 0xFF+1 -> 0x80.
  - 0xFE+2 -> 0x80.
  - 0xFF+2 -> 0x81.
- Read-modify-write to the same address in one EXEC is legal: read is combinational, write lands at the clock edge.
- Latency: exactly 2 enabled cycles per instruction; a skip adds no cycles.
- Reset mid-EXEC: the write is aborted (strobe drops asynchronously) and memory contents are not modified by the sequencer.

Optional Feature:
- Macro: RSSB_OUTPORT_EN.
- Defined: in EXEC with opnd==OUT_ADDR and en:
  - out_data <= diff, out_valid pulses for 1 cycle.
  - mem_write=0.
  - acc and pc update normally.
- Undefined: out_data=0 and out_valid=0 constantly; OUT_ADDR is ordinary RAM.

Decomposition:
- Package rssb_pkg holds:
  - state_t enum {S_FETCH, S_EXEC, S_HALT}.
  - rom_base(WIDTH) function.
  - pc_next(pc, skip) function implementing the ROM-confined wrap.
- One sub-module, rssb_alu (combinational): inputs mem_rdata and acc; outputs diff and skip.

Test Plan:
- Reset, WIDTH=8 -> pc=0x80, acc=0, halted=0, mem_write=0, mem_addr=0x80.
- ROM[0x80]=0x10, RAM[0x10]=5, acc=0 -> EXEC cycle: mem_addr=0x10, mem_write=1, mem_wdata=5; afterwards acc=5, pc=0x81, RAM[0x10]=5, instr_done pulses once.
- ROM[0x81]=0x11, RAM[0x11]=3, acc=5 -> diff=0xFE, RAM[0x11]=0xFE, acc=0xFE, pc=0x83 (skip).
- Operand 0x90 (ROM) -> mem_write stays 0, acc updated, ROM unchanged. Operand 0xFF -> halted=1 with pc frozen over 10 further cycles.
- pc=0xFF with a non-skip instruction -> pc=0x80. pc=0xFE with a skip -> pc=0x80.
- en=0 held 3 cycles in EXEC -> no write and state/pc/acc unchanged. rst pulsed mid-EXEC -> mem_write falls the same cycle and target RAM is unchanged. With RSSB_OUTPORT_EN, operand 0 -> out_valid pulse with out_data=diff and RAM[0] untouched.
